// File: rtl/range_union_engine.sv
// range_union_engine: buffers up to MAX_RANGES inclusive [lo,hi] ranges, sorts by lo, merges overlaps, reports union size and count.
// Latency: done rises 3n+1 cycles after the in_last beat is accepted (n SORT + n MERGE + n SUM cycles, then DONE).
// Backpressure: in_ready only in IDLE; the result is held in DONE until restart. Optional query port under `RANGE_QUERY_EN.
module range_union_engine #(
  parameter int MAX_RANGES = 182,
  parameter int WIDTH      = 50,
  parameter int SUM_WIDTH  = 64,
  parameter int CW         = $clog2(MAX_RANGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_lo,
  input  logic [WIDTH-1:0]     in_hi,
  input  logic                 in_last,
  input  logic                 restart,
  output logic                 done,
  output logic [SUM_WIDTH-1:0] result,
  output logic [CW-1:0]        merged_count,
  output logic                 overflow
`ifdef RANGE_QUERY_EN
  ,
  input  logic                 q_valid,
  output logic                 q_ready,
  input  logic [WIDTH-1:0]     q_id,
  output logic                 r_valid,
  output logic                 r_hit
`endif
);

  localparam int IW = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;
  localparam logic [CW-1:0] N_MAX = CW'(MAX_RANGES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } range_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SORT,
    ST_MERGE,
    ST_SUM,
    ST_DONE
  } state_t;

  state_t                state, state_nx;
  range_t                mem [MAX_RANGES];
  logic [MAX_RANGES-1:0] vld;
  logic [CW-1:0]         n;
  logic [CW-1:0]         cnt;
  logic                  cnt_last;
  logic [IW-1:0]         i_idx;
  logic [IW-1:0]         j_idx;
  range_t                beat;
  range_t                ent_i;
  range_t                ent_j;
  range_t                ent_s;
  logic [WIDTH:0]        span;
  logic                  restart_take;

  assign in_ready = (state == ST_IDLE);
  assign done     = (state == ST_DONE);
  assign cnt_last = (cnt == n - ONE_C);

  // A reversed pair is normalised on the way in so the rest of the pipe can assume lo<=hi.
  assign beat.lo = (in_lo > in_hi) ? in_hi : in_lo;
  assign beat.hi = (in_lo > in_hi) ? in_lo : in_hi;

  assign ent_i = mem[i_idx];
  assign ent_j = mem[j_idx];
  assign ent_s = mem[cnt[IW-1:0]];

  // hi >= lo always holds here, so the extra bit only has to carry the full-range case.
  assign span = {1'b0, ent_s.hi} - {1'b0, ent_s.lo} + {{WIDTH{1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state: each processing phase lasts exactly n cycles, tracked by cnt.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid && in_last) state_nx = ST_SORT;
      ST_SORT:  if (cnt_last) state_nx = ST_MERGE;
      ST_MERGE: if (cnt_last) state_nx = ST_SUM;
      ST_SUM:   if (cnt_last) state_nx = ST_DONE;
      ST_DONE:  if (restart_take) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Datapath: capture, odd-even transposition sort, single-pass merge, then per-entry accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      n            <= '0;
      cnt          <= '0;
      i_idx        <= '0;
      j_idx        <= '0;
      vld          <= '0;
      result       <= '0;
      merged_count <= '0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (in_valid) begin
            if (n == N_MAX) begin
              overflow <= 1'b1;
            end else begin
              mem[n[IW-1:0]] <= beat;
              n              <= n + ONE_C;
            end
          end
        end
        ST_SORT: begin
          cnt <= cnt_last ? '0 : cnt + ONE_C;
          // Even cycles pair (0,1),(2,3)..; odd cycles pair (1,2),(3,4)..; pairs in one cycle never overlap.
          for (int k = 0; k < MAX_RANGES - 1; k++) begin
            if ((k % 2) == int'(cnt[0]) && (k + 1) < int'(n) && mem[k].lo > mem[k+1].lo) begin
              mem[k]   <= mem[k+1];
              mem[k+1] <= mem[k];
            end
          end
        end
        ST_MERGE: begin
          cnt <= cnt_last ? '0 : cnt + ONE_C;
          if (cnt == '0) begin
            i_idx <= '0;
            j_idx <= IW'(1);
            for (int k = 0; k < MAX_RANGES; k++) vld[k] <= (k < int'(n));
          end else begin
            // Strict overlap only: lo[j]==hi[i]+1 stays a separate range.
            if (ent_j.lo <= ent_i.hi) begin
              if (ent_j.hi > ent_i.hi) mem[i_idx].hi <= ent_j.hi;
              vld[j_idx] <= 1'b0;
            end else begin
              i_idx <= j_idx;
            end
            j_idx <= j_idx + IW'(1);
          end
        end
        ST_SUM: begin
          cnt <= cnt_last ? '0 : cnt + ONE_C;
          if (vld[cnt[IW-1:0]]) begin
            result       <= result + SUM_WIDTH'(span);
            merged_count <= merged_count + ONE_C;
          end
        end
        ST_DONE: begin
          if (restart_take) begin
            n            <= '0;
            result       <= '0;
            merged_count <= '0;
            overflow     <= 1'b0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef RANGE_QUERY_EN
  logic          q_pend;
  logic [IW-1:0] q_idx;
  logic [WIDTH-1:0] q_key;
  range_t        ent_q;
  logic          q_accept;
  logic          q_in;
  logic          q_past;
  logic          q_end_idx;

  assign q_ready      = (state == ST_DONE) && !q_pend;
  assign restart_take = (state == ST_DONE) && restart && !q_pend;
  assign q_accept     = q_valid && q_ready && !restart_take;
  assign ent_q        = mem[q_idx];
  assign q_in         = vld[q_idx] && (ent_q.lo <= q_key) && (q_key <= ent_q.hi);
  assign q_past       = vld[q_idx] && (ent_q.lo > q_key);
  assign q_end_idx    = (CW'(q_idx) == n - ONE_C);

  // Query scan: merged entries are sorted and disjoint, so the first entry past q_id ends the search.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_pend  <= 1'b0;
      q_idx   <= '0;
      q_key   <= '0;
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (q_pend) begin
        if (q_in || q_past || q_end_idx) begin
          q_pend  <= 1'b0;
          r_valid <= 1'b1;
          r_hit   <= q_in;
        end else begin
          q_idx <= q_idx + IW'(1);
        end
      end else if (q_accept) begin
        q_pend <= 1'b1;
        q_idx  <= '0;
        q_key  <= q_id;
      end
    end
  end
`else
  assign restart_take = (state == ST_DONE) && restart;
`endif

endmodule

// File: tb/tb_range_union_engine.sv
// tb_range_union_engine: directed jobs checked against a behavioural union model and hand-computed values.
// Latency: each job is expected to raise done 3n+1 cycles after its last beat; every cycle is compared.
// Backpressure: in_ready expected high whenever no job is in flight.
module tb_range_union_engine;
  localparam int MAXR = 4;
  localparam int W    = 50;
  localparam int SW   = 64;
  localparam int CWL  = $clog2(MAXR + 1);
  localparam int BIG  = 1 << 30;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_lo;
  logic [W-1:0]   in_hi;
  logic           in_last;
  logic           restart;
  logic           done;
  logic [SW-1:0]  result;
  logic [CWL-1:0] merged_count;
  logic           overflow;
`ifdef RANGE_QUERY_EN
  logic           q_valid;
  logic           q_ready;
  logic [W-1:0]   q_id;
  logic           r_valid;
  logic           r_hit;
`endif

  range_union_engine #(.MAX_RANGES(MAXR), .WIDTH(W), .SUM_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi), .in_last(in_last), .restart(restart),
    .done(done), .result(result), .merged_count(merged_count), .overflow(overflow)
`ifdef RANGE_QUERY_EN
    , .q_valid(q_valid), .q_ready(q_ready), .q_id(q_id), .r_valid(r_valid), .r_hit(r_hit)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Job under test and model expectations.
  longint job_lo[$];
  longint job_hi[$];
  longint m_res;
  int     m_cnt;
  bit     m_ovf;
  int     m_n;
  int     t_busy_start = BIG;
  int     t_done_start = BIG;
  int     t_idle_again = BIG;
  bit     chk_en = 1'b0;
  bit     er, ed;

  task automatic add(input longint lo, input longint hi);
    job_lo.push_back(lo);
    job_hi.push_back(hi);
  endtask

  task automatic clear_job();
    job_lo.delete();
    job_hi.delete();
  endtask

  // Union size by interval sweep over the first MAXR ranges.
  task automatic model_job();
    longint lo_a[$];
    longint hi_a[$];
    longint cur_lo, cur_hi, t;
    m_n = 0;
    m_ovf = 1'b0;
    for (int b = 0; b < job_lo.size(); b++) begin
      if (m_n < MAXR) begin
        lo_a.push_back(job_lo[b] < job_hi[b] ? job_lo[b] : job_hi[b]);
        hi_a.push_back(job_lo[b] < job_hi[b] ? job_hi[b] : job_lo[b]);
        m_n++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    for (int a = 0; a < m_n; a++)
      for (int b = a + 1; b < m_n; b++)
        if (lo_a[b] < lo_a[a]) begin
          t = lo_a[a]; lo_a[a] = lo_a[b]; lo_a[b] = t;
          t = hi_a[a]; hi_a[a] = hi_a[b]; hi_a[b] = t;
        end
    m_res = 0;
    m_cnt = 0;
    cur_lo = lo_a[0];
    cur_hi = hi_a[0];
    for (int b = 1; b < m_n; b++) begin
      if (lo_a[b] <= cur_hi) begin
        if (hi_a[b] > cur_hi) cur_hi = hi_a[b];
      end else begin
        m_res += cur_hi - cur_lo + 1;
        m_cnt++;
        cur_lo = lo_a[b];
        cur_hi = hi_a[b];
      end
    end
    m_res += cur_hi - cur_lo + 1;
    m_cnt++;
  endtask

  // Per-cycle comparison against the model's timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      er = !(cyc >= t_busy_start && cyc < t_idle_again);
      ed = (cyc >= t_done_start && cyc < t_idle_again);
      check("in_ready", 64'(in_ready), 64'(er));
      check("done", 64'(done), 64'(ed));
      if (ed) begin
        check("result", result, m_res);
        check("merged_count", 64'(merged_count), 64'(m_cnt));
        check("overflow", 64'(overflow), 64'(m_ovf));
      end
    end
  end

  // Drives the job one beat per cycle; k is the cycle the last beat is presented (accepted at its closing edge).
  task automatic send_beats(output int k);
    k = 0;
    for (int b = 0; b < job_lo.size(); b++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_lo    = W'(job_lo[b]);
      in_hi    = W'(job_hi[b]);
      in_last  = (b == job_lo.size() - 1);
      k = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_job(input string nm, input longint x_res, input int x_cnt, input bit x_ovf, input int x_lat);
    int k;
    int seen;
    t_busy_start = BIG;
    t_done_start = BIG;
    t_idle_again = BIG;
    model_job();
    check({nm, "_model_res"}, m_res, x_res);
    check({nm, "_model_cnt"}, 64'(m_cnt), 64'(x_cnt));
    check({nm, "_model_lat"}, 64'(3 * m_n + 1), 64'(x_lat));
    send_beats(k);
    t_busy_start = k + 1;
    t_done_start = k + 3 * m_n + 1;
    seen = -1;
    for (int c = 0; c < 100 && seen < 0; c++) begin
      @(negedge clk);
      if (done) seen = cyc;
    end
    check({nm, "_latency"}, 64'(seen - k), 64'(x_lat));
    if (seen >= 0) begin
      check({nm, "_res"}, result, x_res);
      check({nm, "_cnt"}, 64'(merged_count), 64'(x_cnt));
      check({nm, "_ovf"}, 64'(overflow), 64'(x_ovf));
    end
  endtask

  task automatic do_restart(input string nm);
    @(posedge clk); #1;
    restart = 1'b1;
    t_idle_again = cyc + 1;
    @(posedge clk); #1;
    restart = 1'b0;
    check({nm, "_rs_done"}, 64'(done), 64'(0));
    check({nm, "_rs_ready"}, 64'(in_ready), 64'(1));
    check({nm, "_rs_res"}, result, 64'(0));
    check({nm, "_rs_cnt"}, 64'(merged_count), 64'(0));
    check({nm, "_rs_ovf"}, 64'(overflow), 64'(0));
  endtask

`ifdef RANGE_QUERY_EN
  task automatic query(input longint id, input bit x_hit);
    int pulses;
    bit got;
    @(posedge clk); #1;
    check("q_ready", 64'(q_ready), 64'(1));
    q_valid = 1'b1;
    q_id    = W'(id);
    @(posedge clk); #1;
    q_valid = 1'b0;
    pulses = 0;
    got = 1'b0;
    for (int c = 0; c < 3 * MAXR + 4; c++) begin
      @(negedge clk);
      if (r_valid) begin
        pulses++;
        got = r_hit;
      end
    end
    check("q_pulses", 64'(pulses), 64'(1));
    check("q_hit", 64'(got), 64'(x_hit));
  endtask
`endif

  task automatic load_test1();
    clear_job();
    add(3, 5); add(10, 14); add(16, 20); add(12, 18);
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_lo = '0; in_hi = '0; in_last = 1'b0; restart = 1'b0;
`ifdef RANGE_QUERY_EN
    q_valid = 1'b0; q_id = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 64'(in_ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_res", result, 64'(0));
    check("rst_cnt", 64'(merged_count), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
`ifdef RANGE_QUERY_EN
    check("rst_q_ready", 64'(q_ready), 64'(0));
    check("rst_r_valid", 64'(r_valid), 64'(0));
`endif
    chk_en = 1'b1;

    load_test1();
    run_job("t1", 14, 2, 1'b0, 13);
`ifdef RANGE_QUERY_EN
    query(1, 1'b0); query(5, 1'b1); query(8, 1'b0);
    query(11, 1'b1); query(17, 1'b1); query(32, 1'b0);
`endif
    do_restart("t1");

    clear_job(); add(7, 7);
    run_job("t2", 1, 1, 1'b0, 4);
    do_restart("t2");

    clear_job(); add(1, 100); add(20, 30); add(1, 100);
    run_job("t3a", 100, 1, 1'b0, 10);
    do_restart("t3a");

    clear_job(); add(9, 2);
    run_job("t3b", 8, 1, 1'b0, 4);
    do_restart("t3b");

    clear_job(); add(1, 5); add(5, 9);
    run_job("t3c", 9, 1, 1'b0, 7);
    do_restart("t3c");

    clear_job(); add(1, 5); add(6, 9);
    run_job("t3d", 9, 2, 1'b0, 7);
    do_restart("t3d");

    clear_job(); add(40, 50); add(30, 35); add(10, 20); add(0, 5);
    run_job("rev", 34, 4, 1'b0, 13);
    do_restart("rev");

    clear_job(); add(0, 64'h3_FFFF_FFFF_FFFF);
    run_job("wide", 64'h4_0000_0000_0000, 1, 1'b0, 4);
    do_restart("wide");

    clear_job(); add(1, 1); add(3, 3); add(5, 5); add(7, 7); add(9, 9); add(11, 11);
    run_job("t4", 4, 4, 1'b1, 13);
    do_restart("t4");

    // Abort a job with reset in its second SORT cycle, then rerun it.
    chk_en = 1'b0;
    load_test1();
    send_beats(k);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_ready", 64'(in_ready), 64'(1));
    check("t5_done", 64'(done), 64'(0));
    check("t5_res", result, 64'(0));
    check("t5_cnt", 64'(merged_count), 64'(0));
    check("t5_ovf", 64'(overflow), 64'(0));
    t_busy_start = BIG;
    t_done_start = BIG;
    t_idle_again = BIG;
    chk_en = 1'b1;
    load_test1();
    run_job("t5", 14, 2, 1'b0, 13);
    do_restart("t5");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
